// File: rtl/inst_sequencer_pkg.sv
// rtl/inst_sequencer_pkg.sv - shared widths, instruction constants and FSM encodings for inst_sequencer
//
// Contents:
//   ADDR_WIDTH  default program-counter / instruction-memory address width
//   I_WIDTH     instruction word width
//   EXEC_BIT    bit position of the EXEC flag inside an instruction word
//   INSTR_ZERO  the idle (no-op, EXEC=0) instruction word
//   ST_*        sequencer FSM state encodings
//   cnt_width   width needed to hold a count 0..n (at least 1 bit)
package inst_sequencer_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int I_WIDTH    = 32;
  localparam int EXEC_BIT   = 31;

  localparam logic [I_WIDTH-1:0] INSTR_ZERO = '0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/inst_sequencer_drain_counter.sv
// rtl/inst_sequencer_drain_counter.sv - loadable down-counter that times the DRAIN phase
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset, clears the count
//   load        load load_value (takes priority over enable)
//   load_value  value loaded on load
//   enable      decrement by one while nonzero
//   zero        high when the count is zero
module drain_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - streams a program from instruction memory to a downstream controller
//
// Issues prog_len words from address 0 of a one-cycle-latency instruction memory,
// then holds the instruction output at zero for DRAIN_CYCLES idle cycles so the
// downstream pipeline can retire, then pulses done_o.
//
// Optional feature: define SEQ_LOOP_EN to add loop_cnt_i and repeat the program
// loop_cnt_i times (0 treated as 1) with only a PRIME bubble between passes.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        start request, only looked at in IDLE
//   prog_len_i     number of instructions to issue, latched on start
//   imem_addr_o    registered instruction-memory read address
//   imem_rdata_i   instruction-memory data, valid one cycle after its address
//   instruction_o  registered instruction word to the downstream controller
//   busy_o         high from the start-accept cycle through the done cycle
//   done_o         one-cycle completion pulse
//   loop_cnt_i     (SEQ_LOOP_EN only) program repetition count, latched on start
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int PC_WIDTH     = ADDR_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [PC_WIDTH-1:0] prog_len_i,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic [I_WIDTH-1:0]  imem_rdata_i,
  output logic [I_WIDTH-1:0]  instruction_o,
  output logic                busy_o,
  output logic                done_o
`ifdef SEQ_LOOP_EN
  ,
  input  logic [7:0]          loop_cnt_i
`endif
);

  localparam int                CNT_W      = cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  logic [2:0]          state;
  logic [PC_WIDTH-1:0] len_q;
  logic [PC_WIDTH-1:0] len_m1;
  logic [PC_WIDTH-1:0] issue_cnt;
  logic                addr_at_end;
  logic                last_issue;
  logic                pass_again;
  logic                drain_load;
  logic                drain_zero;

`ifdef SEQ_LOOP_EN
  logic [7:0]          loops_left;
  assign pass_again = (loops_left > 8'd1);
`else
  assign pass_again = 1'b0;
`endif

  assign len_m1      = len_q - PC_WIDTH'(1);
  // Address saturates at the last program word so it never runs past the program.
  assign addr_at_end = (imem_addr_o == len_m1);
  assign last_issue  = (state == ST_RUN) && (issue_cnt == len_m1);
  assign drain_load  = last_issue && !pass_again;

  // The drain counter is loaded with the full count on RUN exit; the first DRAIN
  // cycle still presents the last issued word, so DRAIN lasts DRAIN_CYCLES+1 cycles
  // and exactly DRAIN_CYCLES zero cycles follow the last instruction.
  drain_counter #(
    .WIDTH (CNT_W)
  ) u_drain_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (drain_load),
    .load_value (DRAIN_LOAD),
    .enable     (state == ST_DRAIN),
    .zero       (drain_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      imem_addr_o   <= '0;
      instruction_o <= INSTR_ZERO;
      len_q         <= '0;
      issue_cnt     <= '0;
`ifdef SEQ_LOOP_EN
      loops_left    <= 8'd0;
`endif
    end else begin
      // Only RUN cycles load a real word; everything else issues the no-op.
      instruction_o <= INSTR_ZERO;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (prog_len_i != '0) begin
              len_q       <= prog_len_i;
              imem_addr_o <= '0;
              issue_cnt   <= '0;
`ifdef SEQ_LOOP_EN
              loops_left  <= (loop_cnt_i == 8'd0) ? 8'd1 : loop_cnt_i;
`endif
              state       <= ST_PRIME;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_PRIME: begin
          if (!addr_at_end) imem_addr_o <= imem_addr_o + PC_WIDTH'(1);
          state <= ST_RUN;
        end
        ST_RUN: begin
          instruction_o <= imem_rdata_i;
          if (!addr_at_end) imem_addr_o <= imem_addr_o + PC_WIDTH'(1);
          if (last_issue) begin
            issue_cnt <= '0;
            if (pass_again) begin
`ifdef SEQ_LOOP_EN
              loops_left <= loops_left - 8'd1;
`endif
              imem_addr_o <= '0;
              state       <= ST_PRIME;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            issue_cnt <= issue_cnt + PC_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_zero) state <= ST_DONE;
        end
        ST_DONE: begin
          imem_addr_o <= '0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // busy_o covers the accept cycle itself, hence the start_i term while IDLE.
  assign busy_o = !rst_i && ((state != ST_IDLE) || start_i);
  assign done_o = !rst_i && (state == ST_DONE);

endmodule
